// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Byte lanes touched by an access. Bit 3 is lane 0 (bits [31:24]),
    // matching the big-endian byte order of the memory.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b1000 >> offset;
            SZ_HALF: m = 4'b1100 >> offset;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Halfwords must sit on even bytes, words on word boundaries.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a big-endian word and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then sign/zero extension; reserved size yields zero.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = 32'h0;
        case (offset)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: data = {{24{~uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{~uns & half_sel[15]}}, half_sel};
            SZ_WORD: data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed register-array data memory with sized, big-endian loads/stores.
// Latency: loads combinational (zero cycles); stores commit on the rising edge.
// Backpressure: none; faulting accesses are dropped and flagged, never stalled.
module data_mem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int TEST_WORD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        fault,
    output logic        err_sticky,
    output logic [15:0] store_count,
    output logic [15:0] test_value
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic             err_sticky_q, err_sticky_d;
    logic [15:0]      store_count_q, store_count_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       offset;
    logic             in_range;
    logic             commit;
    logic [3:0]       lanes;
    logic [31:0]      bit_mask;
    logic [31:0]      wr_data;
    logic [31:0]      ld_data;

    assign idx    = addr[IDX_W+1:2];
    assign offset = addr[1:0];

    // Fault decode; only meaningful while an access is requested.
    always_comb begin
        in_range = (addr[31:2] < 30'(DEPTH));
        fault    = (we | re) & (~in_range | misaligned(size, offset) | (size == SZ_RSVD));
        commit   = we & ~fault;
    end

    // Store merge: replicate the low data across lanes, then keep only the selected lanes.
    always_comb begin
        lanes    = lane_mask(size, offset);
        bit_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        case (size)
            SZ_BYTE: wr_data = {4{wd[7:0]}};
            SZ_HALF: wr_data = {2{wd[15:0]}};
            default: wr_data = wd;
        endcase
        mem_d = mem_q;
        if (commit) begin
            mem_d[idx] = (mem_q[idx] & ~bit_mask) | (wr_data & bit_mask);
        end
    end

    // Error flag latches any fault; store counter wraps naturally at 16 bits.
    always_comb begin
        err_sticky_d  = err_sticky_q | fault;
        store_count_d = store_count_q + {15'd0, commit};
    end

    // State register; reset clears the whole array so stores in flight are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            err_sticky_q  <= 1'b0;
            store_count_q <= 16'h0;
        end else begin
            mem_q         <= mem_d;
            err_sticky_q  <= err_sticky_d;
            store_count_q <= store_count_d;
        end
    end

    // Load path reads the pre-edge array, so a same-cycle store shows old data.
    load_align u_load_align (
        .word   (mem_q[idx]),
        .offset (offset),
        .size   (size),
        .uns    (uns),
        .data   (ld_data)
    );

    assign rd          = (re && !fault) ? ld_data : 32'h0;
    assign err_sticky  = err_sticky_q;
    assign store_count = store_count_q;
    assign test_value  = mem_q[TEST_WORD][15:0];

endmodule

// File: tb/tb_data_mem_sized.sv
// Randomized bench with a byte-array reference model plus pinned directed cases.
// Latency: checks each cycle on the falling edge; model advances on the rising edge.
// Backpressure: not applicable.
module tb_data_mem_sized;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        fault;
    logic        err_sticky;
    logic [15:0] store_count;
    logic [15:0] test_value;

    data_mem_sized #(.DEPTH(DEPTH), .TEST_WORD(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .we          (we),
        .re          (re),
        .size        (size),
        .uns         (uns),
        .wd          (wd),
        .rd          (rd),
        .fault       (fault),
        .err_sticky  (err_sticky),
        .store_count (store_count),
        .test_value  (test_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory as a flat big-endian byte array.
    logic [7:0]  mb [DEPTH*4];
    logic        m_err;
    logic [15:0] m_cnt;
    int          n_run;
    int          n_fail;

    task automatic m_reset();
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
        m_err = 1'b0;
        m_cnt = 16'h0;
    endtask

    function automatic logic m_fault();
        logic bad;
        if (!(we || re)) return 1'b0;
        bad = (size == 2'b11);
        if (size == 2'b01 && addr[0]) bad = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
        if (addr[31:2] >= 30'(DEPTH)) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] m_rd();
        int b;
        logic [7:0]  v;
        logic [15:0] h;
        if (!re || m_fault()) return 32'h0;
        b = int'(addr[7:0]);
        if (size == 2'b00) begin
            v = mb[b];
            return uns ? {24'h0, v} : {{24{v[7]}}, v};
        end else if (size == 2'b01) begin
            h = {mb[b], mb[b+1]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return {mb[b], mb[b+1], mb[b+2], mb[b+3]};
    endfunction

    task automatic m_edge();
        int b;
        if (m_fault()) begin
            m_err = 1'b1;
        end else if (we) begin
            b = int'(addr[7:0]);
            if (size == 2'b00) begin
                mb[b] = wd[7:0];
            end else if (size == 2'b01) begin
                mb[b] = wd[15:8]; mb[b+1] = wd[7:0];
            end else begin
                mb[b] = wd[31:24]; mb[b+1] = wd[23:16]; mb[b+2] = wd[15:8]; mb[b+3] = wd[7:0];
            end
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rd", rd, m_rd());
        chk("fault", {31'h0, fault}, {31'h0, m_fault()});
        chk("err_sticky", {31'h0, err_sticky}, {31'h0, m_err});
        chk("store_count", {16'h0, store_count}, {16'h0, m_cnt});
        chk("test_value", {16'h0, test_value}, {16'h0, mb[2], mb[3]});
    endtask

    task automatic drive(input logic w, input logic r, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        we = w; re = r; size = s; uns = u; addr = a; wd = d;
    endtask

    // One cycle: compare mid-cycle, advance model on the edge, leave just after it.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    logic [15:0] cnt_before;

    initial begin
        n_run  = 0;
        n_fail = 0;
        m_reset();
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #12;
        chk("reset_rd", rd, 32'h0);
        chk("reset_err", {31'h0, err_sticky}, 32'h0);
        chk("reset_count", {16'h0, store_count}, 32'h0);
        chk("reset_tv", {16'h0, test_value}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store then load.
        drive(1, 0, 2'b10, 0, 32'h0, 32'h11112222); step();
        drive(0, 1, 2'b10, 0, 32'h0, 32'h0); #1;
        chk("word_load", rd, 32'h11112222);
        chk("word_tv", {16'h0, test_value}, 32'h2222);
        chk("word_count", {16'h0, store_count}, 32'h1);
        step();

        // Byte merge into a word, then signed/unsigned byte loads.
        drive(1, 0, 2'b10, 0, 32'h4, 32'hAABBCCDD); step();
        drive(1, 0, 2'b00, 0, 32'h6, 32'h000000EE); step();
        drive(0, 1, 2'b10, 0, 32'h4, 32'h0); #1;
        chk("merge_word", rd, 32'hAABBEEDD);
        step();
        drive(0, 1, 2'b00, 0, 32'h6, 32'h0); #1;
        chk("byte_signed", rd, 32'hFFFFFFEE);
        step();
        drive(0, 1, 2'b00, 1, 32'h6, 32'h0); #1;
        chk("byte_unsigned", rd, 32'h000000EE);
        step();

        // Store and load to one address in one cycle: old data now, new data next.
        drive(1, 0, 2'b10, 0, 32'h8, 32'h01020304); step();
        drive(1, 1, 2'b10, 0, 32'h8, 32'hCAFEF00D); #1;
        chk("raw_old", rd, 32'h01020304);
        step();
        drive(0, 1, 2'b10, 0, 32'h8, 32'h0); #1;
        chk("raw_new", rd, 32'hCAFEF00D);
        step();

        // Misaligned halfword store.
        cnt_before = store_count;
        drive(1, 0, 2'b01, 0, 32'h5, 32'h00001234); #1;
        chk("misal_fault", {31'h0, fault}, 32'h1);
        step();
        drive(0, 1, 2'b10, 0, 32'h4, 32'h0); #1;
        chk("misal_sticky", {31'h0, err_sticky}, 32'h1);
        chk("misal_count", {16'h0, store_count}, {16'h0, cnt_before});
        chk("misal_mem", rd, 32'hAABBEEDD);
        step();

        // Out of range: 0x100 would alias word 0 if the index were truncated.
        drive(1, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF); #1;
        chk("oor_fault", {31'h0, fault}, 32'h1);
        chk("oor_rd", rd, 32'h0);
        step();
        drive(0, 1, 2'b10, 0, 32'h0, 32'h0); #1;
        chk("oor_nowrite", rd, 32'h11112222);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 271));
            drive(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
            step();
        end

        // Reset asserted between edges with a store pending.
        drive(1, 0, 2'b10, 0, 32'h4, 32'h12345678); step();
        drive(1, 1, 2'b10, 0, 32'h4, 32'h77777777);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_rd", rd, 32'h0);
        chk("rst_err", {31'h0, err_sticky}, 32'h0);
        chk("rst_count", {16'h0, store_count}, 32'h0);
        chk("rst_tv", {16'h0, test_value}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, 1, 2'b10, 0, 32'h4, 32'h0); #1;
        chk("post_rst_load", rd, 32'h0);
        step();

        // Store counter wrap from a clean reset state.
        for (int i = 0; i < 65535; i++) begin
            drive(1, 0, 2'b10, 0, 32'($urandom_range(0, DEPTH-1)) << 2, $urandom);
            step();
        end
        drive(0, 0, 2'b10, 0, 32'h0, 32'h0); #1;
        chk("count_ffff", {16'h0, store_count}, 32'h0000FFFF);
        drive(1, 0, 2'b00, 0, 32'h3, 32'h5A); step();
        drive(0, 0, 2'b10, 0, 32'h0, 32'h0); #1;
        chk("count_wrap", {16'h0, store_count}, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words, a power of two from 4 to 1024.
REQ-002 SHALL have parameter TEST_WORD, default 0, meaning the word index mirrored on test_value.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port addr, input, 32 bits: byte address.
REQ-006 SHALL have port we, input, 1 bit: store request, sampled on the rising edge.
REQ-007 SHALL have port re, input, 1 bit: load request, qualifying rd and the error checks.
REQ-008 SHALL have port size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port uns, input, 1 bit: 1 zero-extends sub-word loads, 0 sign-extends them.
REQ-010 SHALL have port wd, input, 32 bits: store data, with the least-significant bytes used for sub-word stores.
REQ-011 SHALL have port rd, output, 32 bits: load data, combinational.
REQ-012 SHALL have port fault, output, 1 bit: combinational; the current access is misaligned, out of range or uses the reserved size.
REQ-013 SHALL have port err_sticky, output, 1 bit: registered; set by any faulting access.
REQ-014 SHALL have port store_count, output, 16 bits: registered count of committed stores.
REQ-015 SHALL have port test_value, output, 16 bits: combinational bits [15:0] of word TEST_WORD.

Function
REQ-016 SHALL form word index = addr[31:2] and byte offset = addr[1:0]; word index >= DEPTH is out of range.
REQ-017 SHALL treat an access as misaligned when size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-018 SHALL assert fault only while (we or re) is high and the access is misaligned, out of range or size=11.
REQ-019 SHALL, on a rising edge with we=1 and fault=0, write byte lanes selected by size and offset, big-endian (offset 0 = bits [31:24]):
  - byte: lane = offset, data wd[7:0];
  - halfword: lanes offset and offset+1, data wd[15:0];
  - word: all lanes, data wd.
REQ-020 SHALL leave all unselected lanes unchanged.
REQ-021 SHALL have zero load latency: rd reflects memory contents and inputs combinationally in the same cycle.
REQ-022 SHALL drive rd with the selected byte or halfword, sign- or zero-extended per uns, or the full word, when re=1 and fault=0.
REQ-023 SHALL drive rd to 32'h0 when re=0 or fault=1.
REQ-024 SHALL ignore a faulting store entirely: no memory change and no count increment.
REQ-025 SHALL set err_sticky on a rising edge with fault=1; it clears only on reset.
REQ-026 SHALL increment store_count on each committed store, wrapping FFFF to 0000.
REQ-027 SHALL, with we=1 and re=1 to the same address, return the old data on rd during that cycle; the new data is visible from the next cycle.
REQ-028 SHALL have test_value follow the stored word with no extra latency after the write edge.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear all memory words, err_sticky, store_count and test_value to 0.
REQ-030 SHALL have combinational outputs reflect the cleared state while in reset, and ignore stores while rst_n=0.
REQ-031 SHALL, when reset asserts mid-cycle with a store pending, discard the store; after deassertion, the first rising edge processes normally.

Structure
REQ-032 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and a lane-mask function in a shared package, dmem_pkg.
REQ-033 SHALL implement load alignment and extension in one combinational sub-module, load_align, with ports (word, offset, size, uns, data).
REQ-034 SHALL keep storage as a DEPTH x 32 register array; no vendor RAM macro, because of reset-clear.

Verification
REQ-035 SHALL verify word store then load: addr 0x0, size 10, wd 11112222, then re → rd=11112222, test_value=2222, store_count=1.
REQ-036 SHALL verify byte merge: word 0x4 = AABBCCDD, then byte store 0x6 wd=000000EE → word AABBEEDD; load byte 0x6 uns=0 → FFFFFFEE, uns=1 → 000000EE.
REQ-037 SHALL verify a misaligned half store at 0x5: fault=1, memory unchanged, err_sticky=1 next edge, store_count unchanged.
REQ-038 SHALL verify out of range: DEPTH=64, addr 0x100 with we=1, re=1 → fault=1, rd=0, no write.
REQ-039 SHALL verify wrap: preload store_count via 65535 stores, then one more → 0000.
REQ-040 SHALL verify reset mid-operation: rst_n low between edges after stores → all outputs 0 immediately; a load of 0x4 after release returns 0.
